// File: rtl/reg_write_arbiter_if.sv
// Write-request bus between the three requesters and the register-bank arbiter.
// The master side drives requests; the slave side grants and drives the bank.
interface reg_write_arbiter_if #(
    parameter int WORD_SIZE  = 16,
    parameter int REG_ADDR_W = 3
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [2:0]              req;
    logic [2:0]              lock;
    logic [5:0]              op;
    logic [3*REG_ADDR_W-1:0] addr;
    logic [3*WORD_SIZE-1:0]  wdata;
    logic [2:0]              gnt;
    logic [NUM_REGS-1:0]     regEnable;
    logic                    regLoad;
    logic                    regSclr;
    logic                    regSset;
    logic [WORD_SIZE-1:0]    regInputData;
    logic                    busy;

    modport master (
        output req, lock, op, addr, wdata,
        input  gnt, regEnable, regLoad, regSclr, regSset,
        input  regInputData, busy
    );

    modport slave (
        input  req, lock, op, addr, wdata,
        output gnt, regEnable, regLoad, regSclr, regSset,
        output regInputData, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for the register bank with optional locked bursts.
// Grants are combinational; the bank control strobes are registered.
module reg_write_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int REG_ADDR_W = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               reset,
    reg_write_arbiter_if.slave bus
);
    localparam int         NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [3:0] MAX_CNT  = 4'(MAX_BURST);
    localparam bit         LOCK_EN  = (MAX_BURST > 1);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e                state_q, state_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            owner_q, owner_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            sel;
    logic [1:0]            cand;
    logic                  hit;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [1:0]            sel_op;
    logic [NUM_REGS-1:0]   en_q, en_d;
    logic                  ld_q, ld_d;
    logic                  clr_q, clr_d;
    logic                  set_q, set_d;
    logic [WORD_SIZE-1:0]  data_q, data_d;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;
        sel     = 2'd0;
        cand    = ptr_q;
        if (!reset) begin
            unique case (state_q)
                ARB: begin
                    for (int i = 0; i < 3; i++) begin
                        if (!hit && bus.req[cand]) begin
                            hit = 1'b1;
                            sel = cand;
                        end
                        cand = inc3(cand);
                    end
                    if (hit) begin
                        ptr_d = inc3(sel);
                        if (LOCK_EN && bus.lock[sel]) begin
                            state_d = LOCKED;
                            owner_d = sel;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    sel = owner_q;
                    // A full burst forces a pass so the others get offered first
                    if (cnt_q >= MAX_CNT || !bus.req[owner_q]) begin
                        state_d = ARB;
                        ptr_d   = inc3(owner_q);
                    end else if (bus.lock[owner_q]) begin
                        hit   = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        hit     = 1'b1;
                        state_d = ARB;
                        ptr_d   = inc3(owner_q);
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_comb begin
        sel_addr = bus.addr[int'(sel)*REG_ADDR_W +: REG_ADDR_W];
        sel_op   = bus.op[int'(sel)*2 +: 2];
        en_d     = '0;
        ld_d     = 1'b0;
        clr_d    = 1'b0;
        set_d    = 1'b0;
        data_d   = '0;
        if (hit) begin
            en_d[sel_addr] = 1'b1;
            ld_d   = (sel_op == 2'b01);
            clr_d  = (sel_op == 2'b10);
            set_d  = (sel_op == 2'b11);
            data_d = bus.wdata[int'(sel)*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= 4'd0;
            en_q    <= '0;
            ld_q    <= 1'b0;
            clr_q   <= 1'b0;
            set_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ld_q    <= ld_d;
            clr_q   <= clr_d;
            set_q   <= set_d;
            data_q  <= data_d;
        end
    end

    assign bus.gnt          = hit ? (3'b001 << sel) : 3'b000;
    assign bus.regEnable    = en_q;
    assign bus.regLoad      = ld_q;
    assign bus.regSclr      = clr_q;
    assign bus.regSset      = set_q;
    assign bus.regInputData = data_q;
    assign bus.busy         = (state_q == LOCKED);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: per-cycle vector table plus
// a hand-written mid-burst reset sequence.
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.WORD_SIZE(16), .REG_ADDR_W(3)) bus ();

    reg_write_arbiter #(
        .WORD_SIZE (16),
        .REG_ADDR_W(3),
        .MAX_BURST (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Registered expectations describe outputs visible during the row's cycle,
    // i.e. the result of the previous row's transfer.
    typedef struct {
        logic [2:0]  req;
        logic [2:0]  lock;
        logic [5:0]  op;
        logic [8:0]  addr;
        logic [47:0] wdata;
        logic [2:0]  gnt;
        logic [7:0]  en;
        logic [2:0]  stb;
        logic [15:0] data;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [2:0] req, input logic [2:0] lock,
        input logic [5:0] op, input logic [8:0] addr,
        input logic [47:0] wdata, input logic [2:0] gnt,
        input logic [7:0] en, input logic [2:0] stb,
        input logic [15:0] data, input logic busy);
        vec_t v;
        v.req = req; v.lock = lock; v.op = op; v.addr = addr;
        v.wdata = wdata; v.gnt = gnt; v.en = en; v.stb = stb;
        v.data = data; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] lock,
                         input logic [5:0] op, input logic [8:0] addr,
                         input logic [47:0] wdata);
        bus.req = req; bus.lock = lock; bus.op = op;
        bus.addr = addr; bus.wdata = wdata;
    endtask

    function automatic logic [2:0] stb_now();
        return {bus.regLoad, bus.regSclr, bus.regSset};
    endfunction

    localparam logic [2:0] LD = 3'b100, CL = 3'b010, ST = 3'b001, NO = 3'b000;
    localparam logic [8:0]  A210 = {3'd2, 3'd1, 3'd0};
    localparam logic [47:0] W0 = 48'h0;

    initial begin
        // Reset: grant suppressed, registered outputs cleared
        reset = 1'b1;
        drive(3'b111, 3'b000, 6'b01_01_01, A210, {16'h1, 16'h2, 16'h3});
        @(negedge clk); #1;
        chk("rst_gnt", 64'(bus.gnt), 64'h0);
        @(negedge clk); #1;
        chk("rst_en", 64'(bus.regEnable), 64'h0);
        chk("rst_stb", 64'(stb_now()), 64'h0);
        chk("rst_data", 64'(bus.regInputData), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        reset = 1'b0;
        drive(3'b000, 3'b000, 6'b0, 9'h0, W0);

        // Single load, then idle
        tbl.push_back(mk(3'b001, 0, 6'b00_00_01, {3'd0,3'd0,3'd3}, {16'h0,16'h0,16'h1234}, 3'b001, 8'h00, NO, 16'h0, 0));
        tbl.push_back(mk(3'b000, 0, 6'b0, 9'h0, W0, 3'b000, 8'h08, LD, 16'h1234, 0));
        // Grant 2 to bring the pointer back to 0
        tbl.push_back(mk(3'b100, 0, 6'b11_00_00, {3'd7,3'd0,3'd0}, {16'hffff,16'h0,16'h0}, 3'b100, 8'h00, NO, 16'h0, 0));
        // Round robin 0,1,2,0,1,2
        tbl.push_back(mk(3'b111, 0, 6'b11_10_01, A210, {16'h2c2c,16'h1b1b,16'h0a0a}, 3'b001, 8'h80, ST, 16'hffff, 0));
        tbl.push_back(mk(3'b111, 0, 6'b11_10_01, A210, {16'h2c2c,16'h1b1b,16'h0a0a}, 3'b010, 8'h01, LD, 16'h0a0a, 0));
        tbl.push_back(mk(3'b111, 0, 6'b11_10_01, A210, {16'h2c2c,16'h1b1b,16'h0a0a}, 3'b100, 8'h02, CL, 16'h1b1b, 0));
        tbl.push_back(mk(3'b111, 0, 6'b11_10_01, A210, {16'h2c2c,16'h1b1b,16'h0a0a}, 3'b001, 8'h04, ST, 16'h2c2c, 0));
        tbl.push_back(mk(3'b111, 0, 6'b11_10_01, A210, {16'h2c2c,16'h1b1b,16'h0a0a}, 3'b010, 8'h01, LD, 16'h0a0a, 0));
        tbl.push_back(mk(3'b111, 0, 6'b11_10_01, A210, {16'h2c2c,16'h1b1b,16'h0a0a}, 3'b100, 8'h02, CL, 16'h1b1b, 0));
        // No-op write to register 5
        tbl.push_back(mk(3'b001, 0, 6'b00_00_00, {3'd0,3'd0,3'd5}, {16'h0,16'h0,16'h5555}, 3'b001, 8'h04, ST, 16'h2c2c, 0));
        // ptr=1 with req=011: clear by 1, then set by 0
        tbl.push_back(mk(3'b011, 0, 6'b00_10_11, {3'd0,3'd6,3'd4}, {16'h0,16'h6666,16'h4444}, 3'b010, 8'h20, NO, 16'h5555, 0));
        tbl.push_back(mk(3'b011, 0, 6'b00_10_11, {3'd0,3'd6,3'd4}, {16'h0,16'h6666,16'h4444}, 3'b001, 8'h40, CL, 16'h6666, 0));
        tbl.push_back(mk(3'b000, 0, 6'b0, 9'h0, W0, 3'b000, 8'h10, ST, 16'h4444, 0));
        // Grant 1 so the pointer sits at 2
        tbl.push_back(mk(3'b010, 0, 6'b00_01_00, {3'd0,3'd1,3'd0}, {16'h0,16'h0001,16'h0}, 3'b010, 8'h00, NO, 16'h0, 0));
        // Locked burst by 2: four grants, one forced pass, then 0 and 1
        tbl.push_back(mk(3'b111, 3'b100, 6'b01_01_01, A210, {16'hc000,16'hb000,16'ha000}, 3'b100, 8'h02, LD, 16'h0001, 0));
        tbl.push_back(mk(3'b111, 3'b100, 6'b01_01_01, A210, {16'hc000,16'hb000,16'ha000}, 3'b100, 8'h04, LD, 16'hc000, 1));
        tbl.push_back(mk(3'b111, 3'b100, 6'b01_01_01, A210, {16'hc000,16'hb000,16'ha000}, 3'b100, 8'h04, LD, 16'hc000, 1));
        tbl.push_back(mk(3'b111, 3'b100, 6'b01_01_01, A210, {16'hc000,16'hb000,16'ha000}, 3'b100, 8'h04, LD, 16'hc000, 1));
        tbl.push_back(mk(3'b111, 3'b100, 6'b01_01_01, A210, {16'hc000,16'hb000,16'ha000}, 3'b000, 8'h04, LD, 16'hc000, 1));
        tbl.push_back(mk(3'b111, 3'b100, 6'b01_01_01, A210, {16'hc000,16'hb000,16'ha000}, 3'b001, 8'h00, NO, 16'h0, 0));
        tbl.push_back(mk(3'b111, 3'b100, 6'b01_01_01, A210, {16'hc000,16'hb000,16'ha000}, 3'b010, 8'h01, LD, 16'ha000, 0));
        tbl.push_back(mk(3'b000, 0, 6'b0, 9'h0, W0, 3'b000, 8'h02, LD, 16'hb000, 0));
        // Lock by 0, dropped lock gives one final write
        tbl.push_back(mk(3'b001, 3'b001, 6'b00_00_01, {3'd0,3'd0,3'd3}, {16'h0,16'h0,16'h3333}, 3'b001, 8'h00, NO, 16'h0, 0));
        tbl.push_back(mk(3'b001, 3'b000, 6'b00_00_01, {3'd0,3'd0,3'd3}, {16'h0,16'h0,16'h3333}, 3'b001, 8'h08, LD, 16'h3333, 1));
        tbl.push_back(mk(3'b000, 0, 6'b0, 9'h0, W0, 3'b000, 8'h08, LD, 16'h3333, 0));
        // Pointer at 1 after the final write: 2 wins over 0
        tbl.push_back(mk(3'b101, 0, 6'b10_00_00, {3'd0,3'd0,3'd0}, {16'h7777,16'h0,16'h0}, 3'b100, 8'h00, NO, 16'h0, 0));
        tbl.push_back(mk(3'b000, 0, 6'b0, 9'h0, W0, 3'b000, 8'h01, CL, 16'h7777, 0));
        tbl.push_back(mk(3'b000, 0, 6'b0, 9'h0, W0, 3'b000, 8'h00, NO, 16'h0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].lock, tbl[i].op, tbl[i].addr, tbl[i].wdata);
            #1;
            chk($sformatf("v%0d_gnt", i), 64'(bus.gnt), 64'(tbl[i].gnt));
            chk($sformatf("v%0d_en", i), 64'(bus.regEnable), 64'(tbl[i].en));
            chk($sformatf("v%0d_stb", i), 64'(stb_now()), 64'(tbl[i].stb));
            chk($sformatf("v%0d_data", i), 64'(bus.regInputData), 64'(tbl[i].data));
            chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'(tbl[i].busy));
        end

        // Reset in the middle of a locked burst by requester 1 (ptr is 0 here)
        @(negedge clk);
        drive(3'b010, 3'b010, 6'b00_01_00, {3'd0,3'd2,3'd0}, {16'h0,16'hbeef,16'h0});
        #1;
        chk("mb_gnt1", 64'(bus.gnt), 64'b010);
        @(negedge clk); #1;
        chk("mb_gnt2", 64'(bus.gnt), 64'b010);
        chk("mb_busy", 64'(bus.busy), 64'h1);
        reset = 1'b1;
        #1;
        chk("mb_rst_gnt", 64'(bus.gnt), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(3'b000, 3'b000, 6'b0, 9'h0, W0);
        #1;
        chk("mb_busy0", 64'(bus.busy), 64'h0);
        chk("mb_en0", 64'(bus.regEnable), 64'h0);
        chk("mb_stb0", 64'(stb_now()), 64'h0);
        chk("mb_data0", 64'(bus.regInputData), 64'h0);
        @(negedge clk);
        drive(3'b110, 3'b000, 6'b01_01_00, {3'd1,3'd2,3'd0}, {16'h1111,16'hbeef,16'h0});
        #1;
        chk("mb_post_gnt", 64'(bus.gnt), 64'b010);
        @(negedge clk);
        drive(3'b000, 3'b000, 6'b0, 9'h0, W0);
        #1;
        chk("mb_post_en", 64'(bus.regEnable), 64'h04);
        chk("mb_post_data", 64'(bus.regInputData), 64'hbeef);
        chk("mb_post_busy", 64'(bus.busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
